pipe_game_ctrl: RTL and testbench
=================================

PIPE_GAME_CTRL -- requirements
Module: pipe_game_ctrl

Interface
REQ-001 Parameter CNT_BITS_N, default 10, width of pos input.
REQ-002 Parameter PHASE_CNT, default 107, pipe-scroller reload value of pos.
REQ-003 Parameter SCROLL_DIV, default 1000000, clk cycles per scroll tick at base speed (>=4).
REQ-004 Parameter HOLD_CYC, default 50000000, clk cycles start is ignored after game over.
REQ-005 Parameter SCORE_BITS, default 8, score width.
REQ-006 clk  in  1  sole clock, all logic on rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  player button level, not synchronised here.
REQ-009 collide  in  1  level, high while bird overlaps a valid pipe pixel.
REQ-010 pos  in  CNT_BITS_N  current pipe position from the scroller.
REQ-011 scroll_tick  out  1  one-clk pulse advancing the scroller.
REQ-012 pipe_rst  out  1  one-clk pulse resetting the scroller.
REQ-013 state  out  2  IDLE=0, RUN=1, OVER=2.
REQ-014 score  out  SCORE_BITS  pipes passed this game.
REQ-015 game_over  out  1  high exactly while state==OVER.

Function
REQ-016 start_rise SHALL be start high this cycle and low the previous cycle (one register).
REQ-017 IDLE: on start_rise go RUN next cycle; clear score and divider counter on that transition.
REQ-018 RUN: divider counts 0..DIV-1; scroll_tick high for one cycle when counter==DIV-1, counter then wraps to 0.
REQ-019 scroll_tick SHALL be 0 in IDLE and OVER; divider held at 0 outside RUN.
REQ-020 RUN: pipe passed when registered previous pos != PHASE_CNT and pos == PHASE_CNT; score increments by 1 that cycle, saturating at all-ones.
REQ-021 RUN: collide high for 1 cycle -> state OVER next cycle; scroll_tick suppressed in that same cycle; collision beats a simultaneous score event (score still updates).
REQ-022 OVER: hold counter loads HOLD_CYC-1 on entry and decrements to 0; start_rise ignored while counter !=0.
REQ-023 OVER with counter==0 and start_rise: pipe_rst pulses 1 cycle, state -> IDLE; score retained until next IDLE->RUN.
REQ-024 start_rise in RUN SHALL be ignored.
REQ-025 Illegal state code 3 SHALL return to IDLE next cycle with pipe_rst pulsed.
REQ-026 All outputs registered; latency input->output exactly 1 clk.

Reset
REQ-027 rst high: state=IDLE, score=0, scroll_tick=0, game_over=0, divider=0, hold counter=0, edge register=0, previous-pos register=PHASE_CNT, pipe_rst=0.
REQ-028 rst asserted mid-RUN SHALL abort immediately (asynchronous); first cycle after deassert is IDLE with no tick.

Configuration
REQ-029 Macro PIPE_SPEEDUP_EN: when defined, effective DIV = SCROLL_DIV - (SCROLL_DIV/8)*min(score>>3,4), recomputed only when divider wraps; when undefined, DIV = SCROLL_DIV always.

Verification (SCROLL_DIV=4, HOLD_CYC=8, PHASE_CNT=107)
REQ-030 reset, start 0->1 -> state=1 next clk, scroll_tick on every 4th clk thereafter, none before start.
REQ-031 RUN, pos 0 then 107 -> score 0->1 one clk later; pos held 107 for 10 clks -> score stays 1.
REQ-032 RUN, collide 1 clk coincident with tick cycle -> no tick, state=2, game_over=1 next clk.
REQ-033 OVER, start_rise at 3 clks after entry -> ignored; start_rise at 10 clks -> pipe_rst single pulse, state=0.
REQ-034 SCORE_BITS=2, 5 pass events -> score saturates at 3; PIPE_SPEEDUP_EN defined, SCROLL_DIV=16, score=8 -> tick period 14 clks.
REQ-035 rst pulsed mid-RUN with score=5 -> all outputs at reset values immediately, no tick until new start_rise.

Source files
------------

// File: rtl/pipe_game_ctrl.sv
// Game controller for a side-scrolling pipe game: start/run/game-over sequencing, scroll divider, score.
// Optional build macro PIPE_SPEEDUP_EN shortens the scroll period as the score grows.
module pipe_game_ctrl #(
    parameter int CNT_BITS_N = 10,
    parameter int PHASE_CNT  = 107,
    parameter int SCROLL_DIV = 1000000,
    parameter int HOLD_CYC   = 50000000,
    parameter int SCORE_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  collide,
    input  logic [CNT_BITS_N-1:0] pos,
    output logic                  scroll_tick,
    output logic                  pipe_rst,
    output logic [1:0]            state,
    output logic [SCORE_BITS-1:0] score,
    output logic                  game_over
);

    localparam int DIV_W  = $clog2(SCROLL_DIV + 1);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    localparam logic [CNT_BITS_N-1:0] PHASE_POS = CNT_BITS_N'(PHASE_CNT);
    localparam logic [SCORE_BITS-1:0] SCORE_MAX = {SCORE_BITS{1'b1}};
    localparam logic [DIV_W-1:0]      DIV_BASE  = DIV_W'(SCROLL_DIV);
    localparam logic [HOLD_W-1:0]     HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_OVER = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [SCORE_BITS-1:0]   score_q, score_d;
    logic                    tick_q, tick_d;
    logic                    prst_q, prst_d;
    logic                    go_q, go_d;
    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic                    start_q, start_d;
    logic [CNT_BITS_N-1:0]   pos_q, pos_d;

    logic                    start_rise_s;
    logic                    pass_s;
    logic                    wrap_s;
    logic [DIV_W-1:0]        div_lim_s;

`ifdef PIPE_SPEEDUP_EN
    logic [DIV_W-1:0] div_lim_q, div_lim_d;

    // Period shrinks by one eighth of the base for every 8 points, at most four steps.
    function automatic logic [DIV_W-1:0] eff_div(input logic [SCORE_BITS-1:0] sc);
        int unsigned lvl;
        lvl = 32'(sc) >> 3;
        if (lvl > 32'd4) begin
            lvl = 32'd4;
        end else begin
            lvl = lvl;
        end
        return DIV_W'(32'(SCROLL_DIV) - 32'(SCROLL_DIV / 8) * lvl);
    endfunction

    // Scroll period only changes on a divider wrap; a new game restarts at base speed.
    always_comb begin
        div_lim_d = div_lim_q;
        if (state_q == ST_IDLE && start_rise_s) begin
            div_lim_d = DIV_BASE;
        end else if (state_q == ST_RUN && wrap_s) begin
            div_lim_d = eff_div(score_q);
        end else begin
            div_lim_d = div_lim_q;
        end
    end

    // Scroll period register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_lim_q <= DIV_BASE;
        end else begin
            div_lim_q <= div_lim_d;
        end
    end

    assign div_lim_s = div_lim_q;
`else
    assign div_lim_s = DIV_BASE;
`endif

    // Input event detection: button edge, pipe crossing, divider terminal count.
    always_comb begin
        start_d      = start;
        pos_d        = pos;
        start_rise_s = start & ~start_q;
        pass_s       = (pos == PHASE_POS) && (pos_q != PHASE_POS);
        wrap_s       = (div_cnt_q == (div_lim_s - DIV_W'(1)));
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        tick_d    = 1'b0;
        prst_d    = 1'b0;
        div_cnt_d = {DIV_W{1'b0}};
        hold_d    = hold_q;
        case (state_q)
            ST_IDLE: begin
                hold_d = {HOLD_W{1'b0}};
                if (start_rise_s) begin
                    state_d = ST_RUN;
                    score_d = {SCORE_BITS{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (wrap_s) begin
                    div_cnt_d = {DIV_W{1'b0}};
                    tick_d    = ~collide;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                    tick_d    = 1'b0;
                end
                if (pass_s && (score_q != SCORE_MAX)) begin
                    score_d = score_q + SCORE_BITS'(1);
                end else begin
                    score_d = score_q;
                end
                // Collision wins over the tick but the score event in the same cycle still counts.
                if (collide) begin
                    state_d   = ST_OVER;
                    hold_d    = HOLD_LOAD;
                    div_cnt_d = {DIV_W{1'b0}};
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_OVER: begin
                if (hold_q != {HOLD_W{1'b0}}) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (start_rise_s) begin
                    prst_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d = ST_IDLE;
                prst_d  = 1'b1;
                hold_d  = {HOLD_W{1'b0}};
            end
        endcase
        go_d = (state_d == ST_OVER);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            score_q   <= {SCORE_BITS{1'b0}};
            tick_q    <= 1'b0;
            prst_q    <= 1'b0;
            go_q      <= 1'b0;
            div_cnt_q <= {DIV_W{1'b0}};
            hold_q    <= {HOLD_W{1'b0}};
            start_q   <= 1'b0;
            pos_q     <= PHASE_POS;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            tick_q    <= tick_d;
            prst_q    <= prst_d;
            go_q      <= go_d;
            div_cnt_q <= div_cnt_d;
            hold_q    <= hold_d;
            start_q   <= start_d;
            pos_q     <= pos_d;
        end
    end

    assign state       = state_q;
    assign score       = score_q;
    assign scroll_tick = tick_q;
    assign pipe_rst    = prst_q;
    assign game_over   = go_q;

endmodule

// File: tb/tb_pipe_game_ctrl.sv
// Bench for pipe_game_ctrl: three instances (base, 2-bit score, slow divider) on shared stimulus,
// checked against a rule-level model, a constant vector table and directed corner sequences.
module tb_pipe_game_ctrl;

`ifdef PIPE_SPEEDUP_EN
    localparam bit SPEEDUP = 1'b1;
`else
    localparam bit SPEEDUP = 1'b0;
`endif
    localparam int HOLD       = 8;
    localparam int PH         = 107;
    localparam int EXP_PERIOD = SPEEDUP ? 14 : 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       collide;
    logic [9:0] pos;
    logic [2:0] tk, pr, go;
    logic [1:0] st [3];
    logic [7:0] sc_a, sc_c;
    logic [1:0] sc_b;

    always #5 clk = ~clk;

    pipe_game_ctrl #(.CNT_BITS_N(10), .PHASE_CNT(PH), .SCROLL_DIV(4), .HOLD_CYC(HOLD), .SCORE_BITS(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .collide(collide), .pos(pos),
        .scroll_tick(tk[0]), .pipe_rst(pr[0]), .state(st[0]), .score(sc_a), .game_over(go[0]));
    pipe_game_ctrl #(.CNT_BITS_N(10), .PHASE_CNT(PH), .SCROLL_DIV(4), .HOLD_CYC(HOLD), .SCORE_BITS(2)) u_sat (
        .clk(clk), .rst(rst), .start(start), .collide(collide), .pos(pos),
        .scroll_tick(tk[1]), .pipe_rst(pr[1]), .state(st[1]), .score(sc_b), .game_over(go[1]));
    pipe_game_ctrl #(.CNT_BITS_N(10), .PHASE_CNT(PH), .SCROLL_DIV(16), .HOLD_CYC(HOLD), .SCORE_BITS(8)) u_spd (
        .clk(clk), .rst(rst), .start(start), .collide(collide), .pos(pos),
        .scroll_tick(tk[2]), .pipe_rst(pr[2]), .state(st[2]), .score(sc_c), .game_over(go[2]));

    typedef struct {
        int state;   // 0 idle, 1 run, 2 over
        int score;
        int phase;   // clocks spent in the current scroll period
        int period;
        int hold;    // clocks of lockout remaining after game over
        bit tick;
        bit prst;
    } mdl_t;

    typedef struct {
        bit s;
        bit c;
        int p;
        int st;
        int sc;
        bit tk;
        bit pr;
    } vec_t;

    int   base [3] = '{4, 4, 16};
    int   smax [3] = '{255, 3, 255};
    mdl_t m [3];
    bit   m_prev_start;
    int   m_prev_pos;
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic int eff_period(int b, int sc);
        int lvl;
        lvl = sc / 8;
        if (lvl > 4) lvl = 4;
        return SPEEDUP ? (b - (b / 8) * lvl) : b;
    endfunction

    function automatic mdl_t mstep(mdl_t x, int b, int mx, bit rise, bit pass, bit col);
        mdl_t y;
        y = x;
        y.tick = 1'b0;
        y.prst = 1'b0;
        if (x.state == 0) begin
            if (rise) begin
                y.state = 1; y.score = 0; y.phase = 0; y.period = b;
            end
        end else if (x.state == 1) begin
            if (x.phase == x.period - 1) begin
                y.tick = !col; y.phase = 0; y.period = eff_period(b, x.score);
            end else begin
                y.phase = x.phase + 1;
            end
            if (pass && x.score < mx) y.score = x.score + 1;
            if (col) begin
                y.state = 2; y.hold = HOLD - 1; y.phase = 0;
            end
        end else begin
            if (x.hold > 0) y.hold = x.hold - 1;
            else if (rise) begin
                y.prst = 1'b1; y.state = 0;
            end
        end
        return y;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m[i] = '{state: 0, score: 0, phase: 0, period: base[i], hold: 0, tick: 1'b0, prst: 1'b0};
        end
        m_prev_start = 1'b0;
        m_prev_pos   = PH;
    endtask

    task automatic cmp(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(string tag);
        int sc_act [3];
        sc_act = '{int'(sc_a), int'(sc_b), int'(sc_c)};
        for (int i = 0; i < 3; i++) begin
            cmp($sformatf("%s_u%0d_state", tag, i), int'(st[i]), m[i].state);
            cmp($sformatf("%s_u%0d_score", tag, i), sc_act[i], m[i].score);
            cmp($sformatf("%s_u%0d_tick", tag, i), int'(tk[i]), int'(m[i].tick));
            cmp($sformatf("%s_u%0d_piperst", tag, i), int'(pr[i]), int'(m[i].prst));
            cmp($sformatf("%s_u%0d_gameover", tag, i), int'(go[i]), (m[i].state == 2) ? 1 : 0);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
    task automatic step(bit s, bit c, int p, string tag);
        bit rise;
        bit pass;
        start   = s;
        collide = c;
        pos     = 10'(p);
        @(posedge clk);
        rise = s && !m_prev_start;
        pass = (p == PH) && (m_prev_pos != PH);
        for (int i = 0; i < 3; i++) m[i] = mstep(m[i], base[i], smax[i], rise, pass, c);
        m_prev_start = s;
        m_prev_pos   = p;
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic do_reset(string tag);
        start   = 1'b0;
        collide = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        cmp({tag, "_state"}, int'(st[0]), 0);
        cmp({tag, "_score"}, int'(sc_a), 0);
        cmp({tag, "_tick"}, int'(tk[0]), 0);
        cmp({tag, "_gameover"}, int'(go[0]), 0);
        cmp({tag, "_piperst"}, int'(pr[0]), 0);
        check_all(tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t tbl [26];
    int   cnt;
    bit   seen;
    bit   s_r;
    int   p_r;

    initial begin
        // start, collide, pos, state, score, tick, pipe_rst
        tbl[0]  = '{0, 0, 0,   0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0,   1, 0, 0, 0};
        tbl[2]  = '{1, 0, 0,   1, 0, 0, 0};
        tbl[3]  = '{1, 0, 0,   1, 0, 0, 0};
        tbl[4]  = '{1, 0, 0,   1, 0, 0, 0};
        tbl[5]  = '{1, 0, 0,   1, 0, 1, 0};
        tbl[6]  = '{1, 0, 107, 1, 1, 0, 0};
        tbl[7]  = '{1, 0, 107, 1, 1, 0, 0};
        tbl[8]  = '{1, 0, 107, 1, 1, 0, 0};
        tbl[9]  = '{1, 0, 107, 1, 1, 1, 0};
        tbl[10] = '{0, 0, 0,   1, 1, 0, 0};
        tbl[11] = '{1, 0, 0,   1, 1, 0, 0};
        tbl[12] = '{1, 0, 0,   1, 1, 0, 0};
        tbl[13] = '{1, 1, 0,   2, 1, 0, 0};
        tbl[14] = '{0, 0, 0,   2, 1, 0, 0};
        tbl[15] = '{0, 0, 0,   2, 1, 0, 0};
        tbl[16] = '{1, 0, 0,   2, 1, 0, 0};
        tbl[17] = '{0, 0, 0,   2, 1, 0, 0};
        tbl[18] = '{0, 0, 0,   2, 1, 0, 0};
        tbl[19] = '{0, 0, 0,   2, 1, 0, 0};
        tbl[20] = '{0, 0, 0,   2, 1, 0, 0};
        tbl[21] = '{0, 0, 0,   2, 1, 0, 0};
        tbl[22] = '{1, 0, 0,   0, 1, 0, 1};
        tbl[23] = '{1, 0, 0,   0, 1, 0, 0};
        tbl[24] = '{0, 0, 0,   0, 1, 0, 0};
        tbl[25] = '{1, 0, 0,   1, 0, 0, 0};

        rst = 1'b1; start = 1'b0; collide = 1'b0; pos = 10'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp("reset_state", int'(st[0]), 0);
        cmp("reset_score", int'(sc_a), 0);
        cmp("reset_tick", int'(tk[0]), 0);
        cmp("reset_piperst", int'(pr[0]), 0);
        cmp("reset_gameover", int'(go[0]), 0);
        check_all("reset");
        rst = 1'b0;

        for (int r = 0; r < 26; r++) begin
            step(tbl[r].s, tbl[r].c, tbl[r].p, $sformatf("row%0d", r));
            cmp($sformatf("tbl%0d_state", r), int'(st[0]), tbl[r].st);
            cmp($sformatf("tbl%0d_score", r), int'(sc_a), tbl[r].sc);
            cmp($sformatf("tbl%0d_tick", r), int'(tk[0]), int'(tbl[r].tk));
            cmp($sformatf("tbl%0d_piperst", r), int'(pr[0]), int'(tbl[r].pr));
            cmp($sformatf("tbl%0d_gameover", r), int'(go[0]), (tbl[r].st == 2) ? 1 : 0);
        end

        // Five pipe passes: 2-bit score saturates at 3, 8-bit score reaches 5.
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 0, "sat");
            step(1, 0, 107, "sat");
        end
        cmp("sat_score2", int'(sc_b), 3);
        cmp("sat_score8", int'(sc_a), 5);

        // Collision together with a pass: game ends and the point still counts.
        step(1, 0, 0, "colpass");
        step(1, 1, 107, "colpass");
        cmp("colpass_state", int'(st[0]), 2);
        cmp("colpass_score", int'(sc_a), 6);

        do_reset("midrun_rst");
        for (int k = 0; k < 8; k++) begin
            step(0, 0, 0, "post_rst");
            cmp("post_rst_tick", int'(tk[0]), 0);
        end

        // Drive the slow-divider instance to score 8, then measure one full scroll period.
        step(1, 0, 0, "spd");
        for (int k = 0; k < 8; k++) begin
            step(1, 0, 0, "spd");
            step(1, 0, 107, "spd");
        end
        cmp("spd_score", int'(sc_c), 8);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step(1, 0, 0, "spd");
            if (tk[2]) seen = 1'b1;
        end
        cmp("spd_first_tick", int'(seen), 1);
        cnt  = 0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            step(1, 0, 0, "spd");
            cnt++;
            if (tk[2]) seen = 1'b1;
        end
        cmp("spd_period", cnt, EXP_PERIOD);

        do_reset("rand_rst");
        s_r = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset("rand_async");
                s_r = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) s_r = !s_r;
            case ($urandom_range(0, 3))
                0: p_r = 0;
                1: p_r = PH;
                2: p_r = PH - 1;
                default: p_r = int'($urandom_range(0, 1023));
            endcase
            step(s_r, ($urandom_range(0, 39) == 0), p_r, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
